// File: rtl/clk_div_n.sv
// Counter-based integer clock divider with a runtime-programmable ratio applied at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge stage for 50% duty on odd ratios.
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_valid,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] n_reg, n_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             pend_vld_reg, pend_vld_next;
    logic             clk_pos_reg, clk_pos_next;
    logic             tick_reg, tick_next;

    logic             wrap;
    logic             apply;
    logic             accept;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] n_eff;
    logic [WIDTH-1:0] h_eff;
    logic [WIDTH-1:0] div_clamped;

    assign wrap        = (cnt_reg == (n_reg - WIDTH'(1)));
    assign apply       = en && wrap && pend_vld_reg;
    assign accept      = div_valid && !pend_vld_reg;
    assign cnt_nx      = wrap ? '0 : (cnt_reg + WIDTH'(1));
    // The edge that loads a new ratio must already shape clk_out with the new high phase.
    assign n_eff       = apply ? pend_reg : n_reg;
    assign h_eff       = n_eff >> 1;
    assign div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;

    always_comb begin
        cnt_next      = cnt_reg;
        n_next        = n_reg;
        pend_next     = pend_reg;
        pend_vld_next = pend_vld_reg;
        clk_pos_next  = clk_pos_reg;
        tick_next     = 1'b0;
        if (en) begin
            cnt_next     = cnt_nx;
            clk_pos_next = (cnt_nx < h_eff);
            tick_next    = (cnt_nx == '0);
            if (apply) begin
                n_next        = pend_reg;
                pend_vld_next = 1'b0;
            end
        end
        if (accept) begin
            pend_next     = div_clamped;
            pend_vld_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= DEF_DIV - WIDTH'(1);
            n_reg        <= DEF_DIV;
            pend_reg     <= DEF_DIV;
            pend_vld_reg <= 1'b0;
            clk_pos_reg  <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            n_reg        <= n_next;
            pend_reg     <= pend_next;
            pend_vld_reg <= pend_vld_next;
            clk_pos_reg  <= clk_pos_next;
            tick_reg     <= tick_next;
        end
    end

    assign div_ready = !pend_vld_reg;
    assign div_cur   = n_reg;
    assign tick      = tick_reg;

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic clk_neg_reg;

    // Stretches the high phase by half a clk period, only for odd ratios.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            clk_neg_reg <= 1'b0;
        end else begin
            clk_neg_reg <= clk_pos_reg && n_reg[0];
        end
    end

    assign clk_out = clk_pos_reg || clk_neg_reg;
`else
    assign clk_out = clk_pos_reg;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: vector table for the basic run, hand sequences for corner cases.
module tb_clk_div_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_val;
    logic       div_valid;
    logic       div_ready;
    logic [7:0] div_cur;
    logic       clk_out;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] val;
        logic       co;
        logic       tk;
        logic       rdy;
        logic [7:0] cur;
    } vec_t;

    vec_t vq[$];

    clk_div_n #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at a falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic e, input logic v, input logic [7:0] d);
        en        = e;
        div_valid = v;
        div_val   = d;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            step(1'b1, 1'b0, 8'd0);
            cycles++;
            if (tick) break;
        end
        if (!tick) begin
            n_fail++;
            $display("FAIL wait_tick: no tick within %0d cycles", budget);
        end
    endtask

    task automatic add(input logic e, input logic v, input logic [7:0] d,
                       input logic co, input logic tk, input logic rdy, input logic [7:0] cur);
        vq.push_back('{e, v, d, co, tk, rdy, cur});
    endtask

    initial begin
        int cyc;

        // Default ratio 8, request 5 mid-period, then request 0 (clamped to 2).
        add(1,0,0, 1,1,1,8); add(1,0,0, 1,0,1,8); add(1,0,0, 1,0,1,8); add(1,0,0, 1,0,1,8);
        add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8);
        add(1,0,0, 1,1,1,8); add(1,0,0, 1,0,1,8); add(1,1,5, 1,0,0,8); add(1,0,0, 1,0,0,8);
        add(1,0,0, 0,0,0,8); add(1,0,0, 0,0,0,8); add(1,0,0, 0,0,0,8); add(1,0,0, 0,0,0,8);
        add(1,0,0, 1,1,1,5); add(1,0,0, 1,0,1,5); add(1,0,0, 0,0,1,5); add(1,0,0, 0,0,1,5);
        add(1,0,0, 0,0,1,5); add(1,0,0, 1,1,1,5); add(1,1,0, 1,0,0,5); add(1,0,0, 0,0,0,5);
        add(1,0,0, 0,0,0,5); add(1,0,0, 0,0,0,5); add(1,0,0, 1,1,1,2); add(1,0,0, 0,0,1,2);
        add(1,0,0, 1,1,1,2); add(1,0,0, 0,0,1,2);

        rst       = 1'b1;
        en        = 1'b1;
        div_valid = 1'b0;
        div_val   = 8'd0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", div_ready, 1);
        chk("rst_cur", div_cur, 8);
        rst = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].vld, vq[i].val);
            $display("vec %0d: en=%0d vld=%0d val=%0d -> clk_out=%0d tick=%0d ready=%0d cur=%0d",
                     i, vq[i].en, vq[i].vld, vq[i].val, clk_out, tick, div_ready, div_cur);
            chk($sformatf("vec%0d_clk_out", i), clk_out, vq[i].co);
            chk($sformatf("vec%0d_tick", i), tick, vq[i].tk);
            chk($sformatf("vec%0d_ready", i), div_ready, vq[i].rdy);
            chk($sformatf("vec%0d_cur", i), div_cur, vq[i].cur);
        end

        // Request 8 on a wrap edge of ratio 2: applied one wrap later.
        step(1'b1, 1'b1, 8'd8);
        chk("wrap8_tick", tick, 1);
        chk("wrap8_ready", div_ready, 0);
        chk("wrap8_cur", div_cur, 2);
        step(1'b1, 1'b0, 8'd0);
        chk("wrap8_mid_clk_out", clk_out, 0);
        step(1'b1, 1'b0, 8'd0);
        chk("apply8_tick", tick, 1);
        chk("apply8_cur", div_cur, 8);
        chk("apply8_ready", div_ready, 1);
        wait_tick(20, cyc);
        chk("period8", cyc, 8);
        $display("seq ratio8: period=%0d", cyc);

        // Request 3 coinciding with a wrap: one more 8-period, then 3-periods.
        repeat (7) step(1'b1, 1'b0, 8'd0);
        chk("pre_wrap_clk_out", clk_out, 0);
        step(1'b1, 1'b1, 8'd3);
        chk("wrap3_tick", tick, 1);
        chk("wrap3_ready", div_ready, 0);
        chk("wrap3_cur", div_cur, 8);
        wait_tick(20, cyc);
        chk("extra_period8", cyc, 8);
        chk("apply3_cur", div_cur, 3);
        chk("apply3_ready", div_ready, 1);
        wait_tick(20, cyc);
        chk("period3", cyc, 3);
        chk("period3_clk_out_hi", clk_out, 1);
        step(1'b1, 1'b0, 8'd0);
        chk("period3_clk_out_lo", clk_out, 0);
        wait_tick(20, cyc);
        chk("period3_rest", cyc, 2);
        $display("seq 8->3 at wrap: done");

        // Freeze for 10 cycles with clk_out high.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'd0);
            chk($sformatf("frozen%0d_clk_out", i), clk_out, 1);
            chk($sformatf("frozen%0d_tick", i), tick, 0);
        end
        step(1'b1, 1'b0, 8'd0);
        chk("resume_clk_out", clk_out, 0);
        chk("resume_tick", tick, 0);
        wait_tick(20, cyc);
        chk("resume_rest", cyc, 2);
        $display("seq en low 10 cycles: done");

        // Request 1 is clamped to 2.
        step(1'b1, 1'b1, 8'd1);
        chk("req1_ready", div_ready, 0);
        wait_tick(20, cyc);
        chk("req1_apply_wait", cyc, 2);
        chk("req1_cur", div_cur, 2);
        chk("req1_ready_back", div_ready, 1);
        wait_tick(20, cyc);
        chk("period2", cyc, 2);
        $display("seq clamp 1->2: done");

        // Pending 6 accepted while frozen, then asynchronous reset mid-period.
        step(1'b0, 1'b1, 8'd6);
        chk("pend6_clk_out", clk_out, 1);
        chk("pend6_ready", div_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_clk_out", clk_out, 0);
        chk("async_rst_tick", tick, 0);
        chk("async_rst_ready", div_ready, 1);
        chk("async_rst_cur", div_cur, 8);
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'd0);
        chk("post_rst_tick", tick, 1);
        chk("post_rst_clk_out", clk_out, 1);
        wait_tick(20, cyc);
        chk("post_rst_period", cyc, 8);
        chk("post_rst_cur", div_cur, 8);
        $display("seq reset with pending 6: period=%0d cur=%0d", cyc, div_cur);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
